// File: rtl/prim_fifo_burst_pkg.sv
// Shared types and width helpers for the FIFO burst reader.
// Holds the FSM state enum and clog2-based width functions.
package prim_fifo_burst_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  // Width of a burst length field able to hold 0..n.
  function automatic int len_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Width of the timeout counter; at least one bit even when disabled.
  function automatic int tmo_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/prim_fifo_burst_reader_if.sv
// Handshake bundle: FIFO read port on one side, framed bursts on the other.
// master = burst reader, slave = FIFO/consumer side.
interface prim_fifo_burst_reader_if #(
  parameter int Width  = 16,
  parameter int DepthW = 2,
  parameter int LenW   = 2
);

  logic              fifo_rvalid;
  logic              fifo_rready;
  logic [Width-1:0]  fifo_rdata;
  logic [DepthW-1:0] fifo_rdepth;

  logic              out_valid;
  logic              out_ready;
  logic [Width-1:0]  out_data;
  logic              out_first;
  logic              out_last;
  logic [LenW-1:0]   out_len;

  modport master (
    input  fifo_rvalid,
    input  fifo_rdata,
    input  fifo_rdepth,
    output fifo_rready,
    output out_valid,
    output out_data,
    output out_first,
    output out_last,
    output out_len,
    input  out_ready
  );

  modport slave (
    output fifo_rvalid,
    output fifo_rdata,
    output fifo_rdepth,
    input  fifo_rready,
    input  out_valid,
    input  out_data,
    input  out_first,
    input  out_last,
    input  out_len,
    output out_ready
  );

endinterface

// File: rtl/prim_fifo_burst_reader.sv
// Drains a FIFO read port into framed bursts (first/last/len).
// Ports: clk_i, rst_i (sync, high), flush_i, busy_o, bus (master).
module prim_fifo_burst_reader
  import prim_fifo_burst_pkg::*;
#(
  parameter int Width         = 16,
  parameter int Depth         = 3,
  parameter int BurstLen      = 2,
  parameter int TimeoutCycles = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic flush_i,
  output logic busy_o,
  prim_fifo_burst_reader_if.master bus
);

  localparam int DepthW = $clog2(Depth + 1);
  localparam int LenW   = len_w(BurstLen);
  localparam int TmoW   = tmo_w(TimeoutCycles);

  localparam logic [DepthW-1:0] BurstD = DepthW'(BurstLen);
  localparam logic [LenW-1:0]   BurstL = LenW'(BurstLen);
  localparam logic [LenW-1:0]   LenOne = LenW'(1);
  localparam logic [TmoW-1:0]   TmoMax = TmoW'(TimeoutCycles);
  localparam logic [TmoW-1:0]   TmoOne = TmoW'(1);
  localparam bit                TmoEn  = (TimeoutCycles != 0);

  state_e          state_q, state_d;
  logic [LenW-1:0] beat_q, beat_d;
  logic [LenW-1:0] len_q, len_d;
  logic [TmoW-1:0] tmo_q, tmo_d;

  logic full_go;
  logic short_go;
  logic last_beat;
  logic fire;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      beat_q  <= '0;
      len_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    beat_d          = beat_q;
    len_d           = len_q;
    tmo_d           = tmo_q;
    fire            = 1'b0;
    bus.out_valid   = 1'b0;
    bus.fifo_rready = 1'b0;
    bus.out_first   = 1'b0;
    bus.out_last    = 1'b0;

    // Depth is compared at full width before truncation,
    // so a short burst length is always below BurstLen.
    full_go  = (bus.fifo_rdepth >= BurstD);
    short_go = bus.fifo_rvalid &
               (flush_i | (TmoEn & (tmo_q == TmoMax)));
    last_beat = (beat_q == (len_q - LenOne));

    unique case (state_q)
      IDLE: begin
        if (!bus.fifo_rvalid) begin
          tmo_d = '0;
        end else if (tmo_q != TmoMax) begin
          tmo_d = tmo_q + TmoOne;
        end
        if (full_go || short_go) begin
          len_d   = full_go ? BurstL
                            : LenW'(bus.fifo_rdepth);
          beat_d  = '0;
          tmo_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        bus.out_valid   = bus.fifo_rvalid;
        fire            = bus.out_valid & bus.out_ready;
        bus.fifo_rready = fire;
        bus.out_first   = (beat_q == '0) & bus.out_valid;
        bus.out_last    = last_beat & bus.out_valid;
        if (fire) begin
          beat_d = beat_q + LenOne;
          if (last_beat) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.out_data = bus.fifo_rdata;
  assign bus.out_len  = len_q;
  assign busy_o       = (state_q == BURST);

endmodule

// File: tb/tb_prim_fifo_burst_reader.sv
// Directed bench for prim_fifo_burst_reader with a small FIFO model.
// Checks framing, timeout, flush, backpressure, back-to-back, reset.
module tb_prim_fifo_burst_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic busy;
  logic fifo_clr = 1'b1;
  logic wr_en = 1'b0;
  logic [15:0] wr_data = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prim_fifo_burst_reader_if #(
    .Width(16), .DepthW(2), .LenW(2)
  ) bus ();

  prim_fifo_burst_reader #(
    .Width(16), .Depth(3), .BurstLen(2), .TimeoutCycles(8)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .busy_o  (busy),
    .bus     (bus)
  );

  // Depth-3 FIFO model: pop from head, push at tail.
  logic [15:0] mem [4];
  int cnt = 0;

  always @(posedge clk) begin : fifo_model
    logic [15:0] m [4];
    int c;
    m = mem;
    c = cnt;
    if (fifo_clr) begin
      c = 0;
    end else begin
      if (bus.fifo_rready && c > 0) begin
        for (int i = 0; i < 3; i++) m[i] = m[i+1];
        c--;
      end
      if (wr_en && c < 3) begin
        m[c] = wr_data;
        c++;
      end
    end
    mem <= m;
    cnt <= c;
  end

  assign bus.fifo_rvalid = (cnt != 0);
  assign bus.fifo_rdepth = 2'(cnt);
  assign bus.fifo_rdata  = mem[0];

  // Log of every accepted beat.
  logic [15:0] rx [16];
  int rxn = 0;

  always @(posedge clk) begin
    if (bus.out_valid && bus.out_ready && rxn < 16) begin
      rx[rxn] <= bus.out_data;
      rxn <= rxn + 1;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wstep(input logic [15:0] d);
    wr_en = 1'b1;
    wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_busy(output int n);
    n = 0;
    while (!busy && n < 30) begin
      step();
      n++;
    end
  endtask

  task automatic chk_beat(input string tag,
                          input logic [15:0] d,
                          input logic f, input logic l,
                          input logic [1:0] len);
    chk({tag, "_busy"}, 32'(busy), 1);
    chk({tag, "_valid"}, 32'(bus.out_valid), 1);
    chk({tag, "_data"}, 32'(bus.out_data), 32'(d));
    chk({tag, "_first"}, 32'(bus.out_first), 32'(f));
    chk({tag, "_last"}, 32'(bus.out_last), 32'(l));
    chk({tag, "_len"}, 32'(bus.out_len), 32'(len));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_valid"}, 32'(bus.out_valid), 0);
    chk({tag, "_rready"}, 32'(bus.fifo_rready), 0);
  endtask

  logic [15:0] exp_seq [12];
  int n;

  initial begin
    exp_seq = '{16'hA001, 16'hB002, 16'hC003, 16'hD004,
                16'hE005, 16'hF006, 16'h1007, 16'h2008,
                16'h3009, 16'h400A, 16'h500B, 16'h600C};
    bus.out_ready = 1'b1;
    step();
    step();
    chk_idle("rst");
    chk("rst_len", 32'(bus.out_len), 0);
    chk("rst_first", 32'(bus.out_first), 0);
    chk("rst_last", 32'(bus.out_last), 0);
    rst = 1'b0;
    fifo_clr = 1'b0;
    step();

    // Full burst of two.
    wstep(exp_seq[0]);
    chk_idle("full_d1");
    wstep(exp_seq[1]);
    chk_idle("full_d2");
    step();
    chk_beat("full_b0", exp_seq[0], 1, 0, 2);
    chk("full_b0_rready", 32'(bus.fifo_rready), 1);
    step();
    chk_beat("full_b1", exp_seq[1], 0, 1, 2);
    step();
    chk_idle("full_end");

    // Timeout with a single word.
    wstep(exp_seq[2]);
    wait_busy(n);
    chk("tmo_delay", 32'(n), 9);
    chk_beat("tmo_b0", exp_seq[2], 1, 1, 1);
    step();
    chk_idle("tmo_end");

    // Flush with one word, then flush on empty FIFO.
    wstep(exp_seq[3]);
    chk_idle("fl_pre");
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk_beat("fl_b0", exp_seq[3], 1, 1, 1);
    step();
    chk_idle("fl_end");
    flush = 1'b1;
    step();
    step();
    chk_idle("fl_empty");
    flush = 1'b0;

    // Backpressure for three cycles.
    bus.out_ready = 1'b0;
    wstep(exp_seq[4]);
    wstep(exp_seq[5]);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_beat("bp_hold", exp_seq[4], 1, 0, 2);
      chk("bp_rready", 32'(bus.fifo_rready), 0);
    end
    chk("bp_cnt", 32'(cnt), 2);
    bus.out_ready = 1'b1;
    step();
    chk_beat("bp_b1", exp_seq[5], 0, 1, 2);
    step();
    chk_idle("bp_end");

    // Back-to-back: 4th word lands during the first burst.
    wstep(exp_seq[6]);
    wstep(exp_seq[7]);
    wstep(exp_seq[8]);
    chk_beat("b2b_b0", exp_seq[6], 1, 0, 2);
    wstep(exp_seq[9]);
    chk_beat("b2b_b1", exp_seq[7], 0, 1, 2);
    step();
    chk_idle("b2b_gap");
    step();
    chk_beat("b2b_b2", exp_seq[8], 1, 0, 2);
    step();
    chk_beat("b2b_b3", exp_seq[9], 0, 1, 2);
    step();
    chk_idle("b2b_end");

    // Reset after the first beat of a burst.
    wstep(exp_seq[10]);
    wstep(exp_seq[11]);
    step();
    chk_beat("rb_b0", exp_seq[10], 1, 0, 2);
    step();
    chk_beat("rb_b1", exp_seq[11], 0, 1, 2);
    bus.out_ready = 1'b0;
    rst = 1'b1;
    step();
    chk_idle("rb_rst");
    chk("rb_first", 32'(bus.out_first), 0);
    chk("rb_last", 32'(bus.out_last), 0);
    chk("rb_len", 32'(bus.out_len), 0);
    chk("rb_cnt", 32'(cnt), 1);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    wait_busy(n);
    chk("rb_delay", 32'(n), 9);
    chk_beat("rb_redo", exp_seq[11], 1, 1, 1);
    step();
    chk_idle("rb_end");

    // Whole delivered stream: order kept, nothing lost or repeated.
    chk("seq_count", 32'(rxn), 12);
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("seq_%0d", i), 32'(rx[i]), 32'(exp_seq[i]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
